seq_pattern_detector: RTL

// Programmable sequence detector over a stream of SYM_W-bit symbols (SYM_W=2 maps the
// x1/x2 input pair). Detects a runtime-loaded pattern of PAT_LEN symbols. Supports overlap
// and non-overlap modes, an optional collapse of repeated symbols, and a saturating match

---
 rtl/seq_pattern_detector_pkg.sv | 30 +++
 rtl/seq_pattern_detector_if.sv | 28 ++
 rtl/seq_pattern_detector_sym_history.sv | 31 +++
 rtl/seq_pattern_detector.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

  // Widest symbol and widest flattened pattern the helper below can address.
  localparam int MAX_SYM_W    = 8;
  localparam int MAX_PAT_BITS = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HUNT = 2'd2
  } state_t;

  // Extract symbol idx (0 = oldest/first) of a flattened pattern, zero-extended to MAX_SYM_W.
  function automatic logic [MAX_SYM_W-1:0] pat_sym(
    input logic [MAX_PAT_BITS-1:0] pat,
    input int unsigned             idx,
    input int unsigned             sym_w
  );
    logic [MAX_PAT_BITS-1:0] shifted;
    logic [MAX_SYM_W-1:0]    mask;
    shifted = pat >> (idx * sym_w);
    mask    = '0;
    for (int unsigned b = 0; b < MAX_SYM_W; b++) begin
      if (b < sym_w) mask[b] = 1'b1;
    end
    return shifted[MAX_SYM_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Symbol stream, configuration and status bundle of the sequence detector.
interface seq_det_if #(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic                     sym_valid;
  logic [SYM_W-1:0]         sym;
  logic                     cfg_load;
  logic [PAT_LEN*SYM_W-1:0] cfg_pattern;
  logic                     cfg_overlap;
  logic                     cfg_collapse;
  logic                     match;
  logic [CNT_W-1:0]         match_count;
  logic                     armed;

  // Source of symbols and configuration.
  modport master (
    output sym_valid, sym, cfg_load, cfg_pattern, cfg_overlap, cfg_collapse,
    input  match, match_count, armed
  );

  // The detector itself.
  modport slave (
    input  sym_valid, sym, cfg_load, cfg_pattern, cfg_overlap, cfg_collapse,
    output match, match_count, armed
  );
endinterface

// File: rtl/seq_pattern_detector_sym_history.sv
// Shift register holding the last PAT_LEN accepted symbols; slot 0 is the oldest.
module sym_history #(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     clear,
  input  logic [SYM_W-1:0]         sym_in,
  output logic [PAT_LEN*SYM_W-1:0] hist_flat
);

  logic [SYM_W-1:0] slot_reg [PAT_LEN];

  // New symbols enter at the newest slot and age towards slot 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < PAT_LEN; i++) slot_reg[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < PAT_LEN - 1; i++) slot_reg[i] <= slot_reg[i+1];
      slot_reg[PAT_LEN-1] <= sym_in;
    end
  end

  genvar gi;
  for (gi = 0; gi < PAT_LEN; gi++) begin : g_flat
    assign hist_flat[gi*SYM_W +: SYM_W] = slot_reg[gi];
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable symbol-sequence detector: FSM, fill counter, collapse filter,
// post-shift comparator and saturating match counter.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst,
  seq_det_if.slave bus
);

  localparam int PAT_BITS = PAT_LEN * SYM_W;
  localparam int FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  state_t              state_reg, state_next;
  logic [FILL_W-1:0]   fill_reg, fill_next;
  logic [SYM_W-1:0]    last_reg;
  logic                last_valid_reg;
  logic                match_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [PAT_BITS-1:0] cfg_pattern_reg;
  logic                cfg_overlap_reg;
  logic                cfg_collapse_reg;

  logic                hist_shift, hist_clear;
  logic [PAT_BITS-1:0] hist_flat;
  logic [PAT_BITS-1:0] hist_next;
  logic [PAT_LEN-1:0]  sym_eq;
  logic                pat_eq, accept, fill_done, hit;

  sym_history #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (hist_shift),
    .clear    (hist_clear),
    .sym_in   (bus.sym),
    .hist_flat(hist_flat)
  );

  // Compare the history as it will look after this symbol shifts in.
  assign hist_next = {bus.sym, hist_flat[PAT_BITS-1:SYM_W]};

  genvar gi;
  for (gi = 0; gi < PAT_LEN; gi++) begin : g_cmp
    assign sym_eq[gi] = (pat_sym(MAX_PAT_BITS'(cfg_pattern_reg), gi, SYM_W)
                         == MAX_SYM_W'(hist_next[gi*SYM_W +: SYM_W]));
  end
  assign pat_eq = &sym_eq;

  // Symbol acceptance (with repeat collapse) and match detection.
  always_comb begin
    accept    = bus.sym_valid && (state_reg != S_IDLE) && !bus.cfg_load &&
                !(cfg_collapse_reg && last_valid_reg && (bus.sym == last_reg));
    fill_done = (state_reg == S_FILL) && (fill_reg == FILL_LAST);
    hit       = accept && pat_eq && ((state_reg == S_HUNT) || fill_done);
  end

  // Next-state, fill count and history control.
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    hist_shift = 1'b0;
    hist_clear = 1'b0;
    if (bus.cfg_load) begin
      state_next = S_FILL;
      fill_next  = '0;
      hist_clear = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: ;
        S_FILL: begin
          if (accept) begin
            hist_shift = 1'b1;
            if (!fill_done) begin
              fill_next = fill_reg + FILL_W'(1);
            end else if (hit && !cfg_overlap_reg) begin
              fill_next = '0;
            end else begin
              state_next = S_HUNT;
              fill_next  = FILL_FULL;
            end
          end
        end
        S_HUNT: begin
          if (accept) begin
            hist_shift = 1'b1;
            if (hit && !cfg_overlap_reg) begin
              state_next = S_FILL;
              fill_next  = '0;
            end
          end
        end
        default: begin
          state_next = S_IDLE;
          fill_next  = '0;
        end
      endcase
    end
  end

  // State, fill count and registered match pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      fill_reg  <= '0;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      fill_reg  <= fill_next;
      match_reg <= hit;
    end
  end

  // Configuration capture, last-accepted-symbol tracking and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pattern_reg  <= '0;
      cfg_overlap_reg  <= 1'b0;
      cfg_collapse_reg <= 1'b0;
      last_reg         <= '0;
      last_valid_reg   <= 1'b0;
      count_reg        <= '0;
    end else if (bus.cfg_load) begin
      cfg_pattern_reg  <= bus.cfg_pattern;
      cfg_overlap_reg  <= bus.cfg_overlap;
      cfg_collapse_reg <= bus.cfg_collapse;
      last_reg         <= '0;
      last_valid_reg   <= 1'b0;
      count_reg        <= '0;
    end else begin
      if (accept) begin
        last_reg       <= bus.sym;
        last_valid_reg <= 1'b1;
      end
      if (hit && (count_reg != {CNT_W{1'b1}})) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.match       = match_reg;
  assign bus.match_count = count_reg;
  assign bus.armed       = (state_reg != S_IDLE);

endmodule
